// File: rtl/ex04_seq_ctrl_if.sv
// Handshake bundle for ex04_seq_ctrl: operand request channel and result channel.
// The slave modport is the controller's view; master is the producer/consumer side.
interface ex04_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, op_cin, res_ready,
    input  start_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, op_cin, res_ready,
    output start_ready, res_valid, res_sum, res_cout, res_ovf, busy
  );
endinterface

// File: rtl/ex04_seq_ctrl.sv
// Wide adder built by streaming nibbles through one 4-bit ripple adder (ex04),
// with the carry chained through a register between cycles.

module ex04 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c_s;

  // Four-stage ripple carry chain
  always_comb begin
    c_s    = 5'd0;
    s      = 4'd0;
    c_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    cout = c_s[4];
  end
endmodule

module ex04_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst,
  ex04_seq_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic            carry_r;
  logic [IW-1:0]   idx_r;

  logic [3:0]      add_a_s;
  logic [3:0]      add_b_s;
  logic            add_cin_s;
  logic [3:0]      add_s_s;
  logic            add_cout_s;
  logic            accept_s;
  logic            last_s;
  logic            done_s;

  ex04 u_add (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .s    (add_s_s),
    .cout (add_cout_s)
  );

  assign accept_s = (state_r == IDLE) && bus.start_valid;
  assign last_s   = (idx_r == IW'(NIBBLES - 1));
  assign done_s   = (state_r == DONE);

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (bus.res_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Adder operand select; quiet inputs whenever no nibble is being processed
  always_comb begin
    add_a_s   = 4'd0;
    add_b_s   = 4'd0;
    add_cin_s = 1'b0;
    if (state_r == RUN) begin
      add_a_s   = a_r[idx_r*4 +: 4];
      add_b_s   = b_r[idx_r*4 +: 4];
      add_cin_s = carry_r;
    end else begin
      add_a_s   = 4'd0;
      add_b_s   = 4'd0;
      add_cin_s = 1'b0;
    end
  end

  // State register and nibble datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.op_a;
            b_r     <= bus.op_b;
            carry_r <= bus.op_cin;
            idx_r   <= '0;
            sum_r   <= '0;
          end
        end
        RUN: begin
          sum_r[idx_r*4 +: 4] <= add_s_s;
          carry_r             <= add_cout_s;
          if (!last_s) idx_r <= idx_r + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result fields are gated by DONE so they read zero outside a valid result
  assign bus.start_ready = (state_r == IDLE) && !rst;
  assign bus.busy        = (state_r != IDLE);
  assign bus.res_valid   = done_s;
  assign bus.res_sum     = done_s ? sum_r : '0;
  assign bus.res_cout    = done_s & carry_r;
  assign bus.res_ovf     = done_s & (a_r[W-1] == b_r[W-1]) & (sum_r[W-1] != a_r[W-1]);
endmodule

// File: tb/tb_ex04_seq_ctrl.sv
// Directed bench for ex04_seq_ctrl (NIBBLES=4): one task per scenario, inline checks
// against hand-computed sums, carries and overflow flags.
module tb_ex04_seq_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  ex04_seq_ctrl_if #(.NIBBLES(4)) bus ();

  ex04_seq_ctrl #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for start_ready, accepts one pair, returns cycles until res_valid
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      output int lat);
    int guard;
    guard = 0;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.op_cin      = cin;
    bus.start_valid = 1'b1;
    while (!bus.start_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.start_ready !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready got %b want 0", bus.start_ready); end
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_busy got %b/%b want 0/0", bus.res_valid, bus.busy); end
    n_checks++;
    if (bus.res_sum !== 16'h0000 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_result got %h/%b/%b want 0000/0/0", bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_start_ready got %b want 1", bus.start_ready); end
  endtask

  task automatic test_basic();
    int lat;
    bus.res_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_checks++;
    if (bus.res_sum !== 16'h5555 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_result got %h/%b/%b want 5555/0/0", bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse got %b want 0", bus.res_valid); end
  endtask

  task automatic test_carry_chain();
    int lat;
    bus.res_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || bus.res_sum !== 16'h0000 || bus.res_cout !== 1'b1 || bus.res_ovf !== 1'b0) begin
      n_fail++; $display("FAIL wrap lat %0d got %h/%b/%b want 4 0000/1/0", lat, bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
    send(16'h000F, 16'h0000, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || bus.res_sum !== 16'h0010 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b0) begin
      n_fail++; $display("FAIL cin_chain lat %0d got %h/%b/%b want 4 0010/0/0", lat, bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    bus.res_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || bus.res_sum !== 16'h8000 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pos lat %0d got %h/%b/%b want 4 8000/0/1", lat, bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
    send(16'h8000, 16'h8000, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || bus.res_sum !== 16'h0000 || bus.res_cout !== 1'b1 || bus.res_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_neg lat %0d got %h/%b/%b want 4 0000/1/1", lat, bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    int lat;
    bus.res_ready = 1'b0;
    send(16'h0003, 16'h0004, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.op_a        = 16'h1111;
        bus.op_b        = 16'h1111;
        bus.start_valid = 1'b1;
      end else begin
        bus.start_valid = 1'b0;
      end
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_sum !== 16'h0007 || bus.start_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got v=%b sum=%h rdy=%b want 1/0007/0", i, bus.res_valid, bus.res_sum, bus.start_ready);
      end
      tick();
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    tick();
    n_checks++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got rdy=%b v=%b busy=%b want 1/0/0", bus.start_ready, bus.res_valid, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_start busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.res_ready   = 1'b1;
    bus.op_a        = 16'h8888;
    bus.op_b        = 16'h7777;
    bus.op_cin      = 1'b1;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.start_ready !== 1'b0) begin n_fail++; $display("FAIL rst_forces_ready got %b want 0", bus.start_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_sum !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_run got busy=%b v=%b sum=%h want 0/0/0000", bus.busy, bus.res_valid, bus.res_sum);
    end
    send(16'h0001, 16'h0002, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || bus.res_sum !== 16'h0003 || bus.res_cout !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_txn lat %0d got %h/%b want 4 0003/0", lat, bus.res_sum, bus.res_cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int guard;
    bus.res_ready   = 1'b1;
    bus.op_a        = 16'h0100;
    bus.op_b        = 16'h0200;
    bus.op_cin      = 1'b0;
    bus.start_valid = 1'b1;
    guard = 0;
    while (!bus.start_ready && guard < 20) begin tick(); guard++; end
    t1 = cyc;
    tick();
    bus.op_a = 16'h0F0F;
    bus.op_b = 16'h00F1;
    guard = 0;
    while (!bus.res_valid && guard < 20) begin tick(); guard++; end
    n_checks++;
    if (bus.res_sum !== 16'h0300 || bus.res_cout !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got %h/%b want 0300/0", bus.res_sum, bus.res_cout);
    end
    guard = 0;
    while (!bus.start_ready && guard < 20) begin tick(); guard++; end
    t2 = cyc;
    n_checks++;
    if (t2 - t1 !== 6) begin n_fail++; $display("FAIL b2b_spacing got %0d want 6", t2 - t1); end
    tick();
    bus.start_valid = 1'b0;
    guard = 0;
    while (!bus.res_valid && guard < 20) begin tick(); guard++; end
    n_checks++;
    if (bus.res_sum !== 16'h1000 || bus.res_cout !== 1'b0 || bus.res_ovf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got %h/%b/%b want 1000/0/0", bus.res_sum, bus.res_cout, bus.res_ovf);
    end
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    cyc             = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_a        = 16'h0000;
    bus.op_b        = 16'h0000;
    bus.op_cin      = 1'b0;
    bus.res_ready   = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_back_pressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
